// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO for the UART TX/RX datapath.
// Registered or first-word-fall-through read, occupancy count, thresholds, flush and error pulses.
module fifo_sync_param #(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_DEPTH = 16,
  parameter int AF_THRESH  = SIZE_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_wr_en,
  input  logic [SIZE_DATA-1:0]          i_data,
  input  logic                          i_rd_en,
  output logic [SIZE_DATA-1:0]          o_data,
  output logic                          o_rd_valid,
  output logic [$clog2(SIZE_DEPTH):0]   o_count,
  output logic                          o_fifo_full,
  output logic                          o_fifo_empty,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int AW = $clog2(SIZE_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(SIZE_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overflow_reg;
  logic          underflow_reg;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  // Flush and reset suppress both handshakes; no bypass from write to read when empty.
  assign wr_acc = i_wr_en & ~full  & ~i_flush & ~i_rst;
  assign rd_acc = i_rd_en & ~empty & ~i_flush & ~i_rst;

  always_comb begin
    count_next = count_reg + CW'(wr_acc) - CW'(rd_acc);
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= i_wr_en & full  & ~i_flush;
      underflow_reg <= i_rd_en & empty & ~i_flush;
      if (i_flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (rd_acc) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        count_reg <= count_next;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; i_rd_en only acknowledges it.
      assign o_data     = mem[rd_ptr_reg];
      assign o_rd_valid = ~empty;
    end else begin : g_reg_read
      logic [SIZE_DATA-1:0] data_reg;
      logic                 rd_valid_reg;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          data_reg     <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) begin
            data_reg <= mem[rd_ptr_reg];
          end
        end
      end

      assign o_data     = data_reg;
      assign o_rd_valid = rd_valid_reg;
    end
  endgenerate

  assign o_count        = count_reg;
  assign o_fifo_full    = full;
  assign o_fifo_empty   = empty;
  assign o_almost_full  = (count_reg >= AF_C);
  assign o_almost_empty = (count_reg <= AE_C);
  assign o_overflow     = overflow_reg;
  assign o_underflow    = underflow_reg;

endmodule
